dl11_uart_ctl: RTL and testbench

DL11-style console controller that sequences the existing uart block for the PDP-11 Unibus side.
- Generates the uart's rxclk (16x baud) and txclk (1x baud) from the system clock.
- Drives the uart's four-phase ld_tx/uld_rx req/ack handshakes.
- Exposes RCSR/RBUF/XCSR/XBUF registers to the bus and raises receive/transmit interrupt requests.

---
 rtl/dl11_pkg.sv | 38 +++
 rtl/dl11_uart_ctl_sync2.sv | 25 ++
 rtl/dl11_uart_ctl.sv | 214 +++++++++++++++++++++
 tb/tb_dl11_uart_ctl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 console controller: register offsets,
// CSR bit positions and the transmit/receive sequencer state encodings.
package dl11_pkg;

    localparam logic [1:0] ADDR_RCSR = 2'd0;
    localparam logic [1:0] ADDR_RBUF = 2'd1;
    localparam logic [1:0] ADDR_XCSR = 2'd2;
    localparam logic [1:0] ADDR_XBUF = 2'd3;

    localparam int BIT_DONE  = 7;
    localparam int BIT_READY = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_ERR   = 15;
    localparam int BIT_OVR   = 14;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_REL  = 2'd2,
        T_BUSY = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_REL  = 2'd2
    } rx_state_t;

    // Builds a CSR read word from its status flag and interrupt enable.
    function automatic logic [15:0] csr_word(input logic flag, input logic ie);
        logic [15:0] w;
        w = 16'h0000;
        w[BIT_DONE] = flag;
        w[BIT_IE]   = ie;
        return w;
    endfunction

endpackage

// File: rtl/dl11_uart_ctl_sync2.sv
// Two-flop synchroniser for one uart status/ack line. RESET_VAL lets idle-high
// status lines come out of reset already reading their idle value.
module dl11_uart_ctl_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two flops in series; the second feeds the controller logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dl11_uart_ctl.sv
// DL11-style console controller: generates the uart clocks, sequences the
// uart load/unload four-phase handshakes and exposes RCSR/RBUF/XCSR/XBUF.
//
// Handshake: ld_tx_req / uld_rx_req rise and stay high until the synchronised
// ack is seen high, then fall; the controller then waits for the synchronised
// ack to fall before the next request. No request is raised while ack is high.
module dl11_uart_ctl
    import dl11_pkg::*;
#(
    parameter int RXCLK_HALF  = 163,
    parameter int TXCLK_RATIO = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [15:0] bus_data_in,
    output logic [15:0] bus_data_out,
    output logic        rx_irq,
    output logic        tx_irq,
    output logic        rxclk,
    output logic        txclk,
    output logic        ld_tx_req,
    input  logic        ld_tx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_empty,
    output logic        uld_rx_req,
    input  logic        uld_rx_ack,
    input  logic [7:0]  rx_data,
    output logic        rx_enable,
    input  logic        rx_empty
);

    localparam logic [8:0] RX_LAST = 9'(RXCLK_HALF - 1);
    localparam logic [7:0] TX_LAST = 8'(TXCLK_RATIO / 2 - 1);

    logic [8:0] rx_cnt;
    logic [7:0] tx_div;

    logic ld_tx_ack_s, tx_empty_s, uld_rx_ack_s, rx_empty_s;

    tx_state_t tx_state;
    rx_state_t rx_state;
    logic      tx_seen_busy;

    logic       ready, tie;
    logic       done, rie;
    logic       rbuf_err, rbuf_ovr;
    logic [7:0] rbuf_data;

    logic xbuf_wr, rbuf_rd;
    logic unused_bus_bits;

    assign xbuf_wr         = bus_wr && (bus_addr == ADDR_XBUF);
    assign rbuf_rd         = bus_rd && (bus_addr == ADDR_RBUF);
    assign unused_bus_bits = ^{bus_data_in[15:8]};

    dl11_uart_ctl_sync2 #(.RESET_VAL(1'b0)) u_sync_ld_ack (
        .clk(clk), .reset(reset), .d(ld_tx_ack), .q(ld_tx_ack_s));
    dl11_uart_ctl_sync2 #(.RESET_VAL(1'b1)) u_sync_tx_empty (
        .clk(clk), .reset(reset), .d(tx_empty), .q(tx_empty_s));
    dl11_uart_ctl_sync2 #(.RESET_VAL(1'b0)) u_sync_uld_ack (
        .clk(clk), .reset(reset), .d(uld_rx_ack), .q(uld_rx_ack_s));
    dl11_uart_ctl_sync2 #(.RESET_VAL(1'b1)) u_sync_rx_empty (
        .clk(clk), .reset(reset), .d(rx_empty), .q(rx_empty_s));

    // Baud clock divider: rxclk is 16x baud, txclk divides rxclk rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt <= 9'd0;
            tx_div <= 8'd0;
            rxclk  <= 1'b0;
            txclk  <= 1'b0;
        end else if (rx_cnt == RX_LAST) begin
            rx_cnt <= 9'd0;
            rxclk  <= ~rxclk;
            if (!rxclk) begin
                if (tx_div == TX_LAST) begin
                    tx_div <= 8'd0;
                    txclk  <= ~txclk;
                end else begin
                    tx_div <= tx_div + 8'd1;
                end
            end
        end else begin
            rx_cnt <= rx_cnt + 9'd1;
        end
    end

    // Transmit sequencer: load one byte into the uart and wait for it to drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state     <= T_IDLE;
            ld_tx_req    <= 1'b0;
            tx_data      <= 8'h00;
            ready        <= 1'b1;
            tx_seen_busy <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (xbuf_wr && ready) begin
                        tx_data   <= bus_data_in[7:0];
                        ready     <= 1'b0;
                        ld_tx_req <= 1'b1;
                        tx_state  <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (ld_tx_ack_s) begin
                        ld_tx_req <= 1'b0;
                        tx_state  <= T_REL;
                    end
                end
                T_REL: begin
                    if (!ld_tx_ack_s) begin
                        tx_seen_busy <= 1'b0;
                        tx_state     <= T_BUSY;
                    end
                end
                T_BUSY: begin
                    // The character is out once tx_empty has gone low then high.
                    if (!tx_empty_s) begin
                        tx_seen_busy <= 1'b1;
                    end else if (tx_seen_busy) begin
                        ready    <= 1'b1;
                        tx_state <= T_IDLE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Receive sequencer and RBUF/DONE: unload each byte, flag overruns.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= R_IDLE;
            uld_rx_req <= 1'b0;
            done       <= 1'b0;
            rbuf_data  <= 8'h00;
            rbuf_err   <= 1'b0;
            rbuf_ovr   <= 1'b0;
        end else begin
            if (rbuf_rd) begin
                done <= 1'b0;
            end
            case (rx_state)
                R_IDLE: begin
                    if (!rx_empty_s) begin
                        uld_rx_req <= 1'b1;
                        rx_state   <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (uld_rx_ack_s) begin
                        // A capture overrides a same-cycle RBUF read clear.
                        rbuf_data  <= rx_data;
                        rbuf_err   <= done;
                        rbuf_ovr   <= done;
                        done       <= 1'b1;
                        uld_rx_req <= 1'b0;
                        rx_state   <= R_REL;
                    end
                end
                R_REL: begin
                    if (!uld_rx_ack_s && rx_empty_s) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Interrupt enable bits written through the CSRs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rie <= 1'b0;
            tie <= 1'b0;
        end else if (bus_wr) begin
            if (bus_addr == ADDR_RCSR) rie <= bus_data_in[BIT_IE];
            if (bus_addr == ADDR_XCSR) tie <= bus_data_in[BIT_IE];
        end
    end

    // Registered interrupt requests and uart enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_irq    <= 1'b0;
            tx_irq    <= 1'b0;
            tx_enable <= 1'b0;
            rx_enable <= 1'b0;
        end else begin
            rx_irq    <= done & rie;
            tx_irq    <= ready & tie;
            tx_enable <= 1'b1;
            rx_enable <= 1'b1;
        end
    end

    // Register read mux.
    always_comb begin
        bus_data_out = 16'h0000;
        case (bus_addr)
            ADDR_RCSR: bus_data_out = csr_word(done, rie);
            ADDR_RBUF: bus_data_out = {rbuf_err, rbuf_ovr, 6'b000000, rbuf_data};
            ADDR_XCSR: bus_data_out = csr_word(ready, tie);
            default:   bus_data_out = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_dl11_uart_ctl.sv
// Bench for dl11_uart_ctl: the uart side is modelled by driver tasks that
// answer the load/unload handshakes.
module tb_dl11_uart_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  bus_addr = 2'd0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [15:0] bus_data_in = 16'h0000;
    logic [15:0] bus_data_out;
    logic        rx_irq, tx_irq, rxclk, txclk;
    logic        ld_tx_req;
    logic        ld_tx_ack = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_empty = 1'b1;
    logic        uld_rx_req;
    logic        uld_rx_ack = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_enable;
    logic        rx_empty = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  tx_exp_q[$];

    dl11_uart_ctl dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .rx_irq(rx_irq), .tx_irq(tx_irq), .rxclk(rxclk), .txclk(txclk),
        .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack), .tx_data(tx_data),
        .tx_enable(tx_enable), .tx_empty(tx_empty),
        .uld_rx_req(uld_rx_req), .uld_rx_ack(uld_rx_ack), .rx_data(rx_data),
        .rx_enable(rx_enable), .rx_empty(rx_empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_addr    = a;
        bus_data_in = d;
        bus_wr      = 1'b1;
        tick();
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        bus_addr = a;
        #1;
        d = bus_data_out;
        bus_rd = 1'b1;
        tick();
        bus_rd = 1'b0;
    endtask

    task automatic wait_tx_req(input logic level, output logic ok);
        int n;
        n = 0;
        while (ld_tx_req !== level && n < 40) begin tick(); n++; end
        ok = (ld_tx_req === level);
    endtask

    task automatic wait_rx_req(input logic level, output logic ok);
        int n;
        n = 0;
        while (uld_rx_req !== level && n < 40) begin tick(); n++; end
        ok = (uld_rx_req === level);
    endtask

    // Uart transmit side: accept the pending load and send the character.
    task automatic uart_tx_serve(input string tag);
        logic ok;
        logic [7:0] exp;
        int n;
        wait_tx_req(1'b1, ok);
        check({tag, " ld_tx_req rise"}, ok, 1'b1);
        if (!ok) return;
        exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
        check({tag, " tx_data"}, tx_data, exp);
        ld_tx_ack = 1'b1;
        wait_tx_req(1'b0, ok);
        check({tag, " ld_tx_req fall"}, ok, 1'b1);
        ld_tx_ack = 1'b0;
        ticks(4);
        tx_empty = 1'b0;
        ticks(6);
        bus_addr = 2'd2;
        #1;
        check({tag, " READY low while sending"}, bus_data_out[7], 1'b0);
        tx_empty = 1'b1;
        n = 0;
        while (bus_data_out[7] !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, " READY back"}, bus_data_out[7], 1'b1);
    endtask

    // Uart receive side: present a byte and complete the unload handshake.
    task automatic uart_rx_send(input logic [7:0] b, input string tag);
        logic ok;
        rx_data  = b;
        rx_empty = 1'b0;
        wait_rx_req(1'b1, ok);
        check({tag, " uld_rx_req rise"}, ok, 1'b1);
        if (!ok) begin rx_empty = 1'b1; return; end
        uld_rx_ack = 1'b1;
        wait_rx_req(1'b0, ok);
        check({tag, " uld_rx_req fall"}, ok, 1'b1);
        rx_data    = 8'hEE;
        rx_empty   = 1'b1;
        uld_rx_ack = 1'b0;
        ticks(6);
    endtask

    // Scoreboard side: read RBUF and compare against the oldest expectation.
    task automatic read_rbuf(input string tag);
        logic [15:0] d;
        logic [15:0] exp;
        bus_read(2'd1, d);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, " RBUF"}, d, exp);
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        logic        exp_tx_irq;
    } vec_t;

    vec_t vecs[12];

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] d;
        logic ok;
        int cnt, rises;
        logic prev_rx, prev_tx;

        // Reset values while reset is held.
        ticks(3);
        check("rst rxclk", rxclk, 1'b0);
        check("rst txclk", txclk, 1'b0);
        check("rst tx_enable", tx_enable, 1'b0);
        check("rst ld_tx_req", ld_tx_req, 1'b0);
        check("rst uld_rx_req", uld_rx_req, 1'b0);
        check("rst tx_data", tx_data, 8'h00);
        reset = 1'b0;
        tick();
        check("tx_enable on", tx_enable, 1'b1);
        check("rx_enable on", rx_enable, 1'b1);
        check("rst irqs", {rx_irq, tx_irq}, 2'b00);

        // Register map table.
        vecs[0]  = '{1'b0, 2'd2, 16'h0000, 16'h0080, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 16'hFFFF, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 16'h0000, 16'h0040, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 16'h0040, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 16'h0000, 16'h00C0, 1'b1};
        vecs[8]  = '{1'b1, 2'd2, 16'hFFBF, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 2'd2, 16'h0000, 16'h0080, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("reg vec %0d data", i), d, vecs[i].exp);
                check($sformatf("reg vec %0d tx_irq", i), tx_irq, vecs[i].exp_tx_irq);
            end
        end

        // rxclk half-period in system clocks.
        prev_rx = rxclk;
        cnt = 0;
        while (rxclk === prev_rx && cnt < 400) begin tick(); cnt++; end
        prev_rx = rxclk;
        cnt = 0;
        while (rxclk === prev_rx && cnt < 400) begin tick(); cnt++; end
        check("rxclk half period", cnt, 163);

        // txclk half-period in rxclk rising edges.
        prev_tx = txclk;
        cnt = 0;
        while (txclk === prev_tx && cnt < 6000) begin tick(); cnt++; end
        prev_tx = txclk;
        prev_rx = rxclk;
        rises = 0;
        cnt = 0;
        while (cnt < 6000) begin
            tick();
            cnt++;
            if (rxclk === 1'b1 && prev_rx === 1'b0) rises++;
            prev_rx = rxclk;
            if (txclk !== prev_tx) break;
        end
        check("txclk half period", rises, 8);

        // Single character transmit.
        bus_write(2'd3, 16'h0041);
        tx_exp_q.push_back(8'h41);
        uart_tx_serve("tx1");

        // TIE set: irq drops on the write, second write while busy is ignored.
        bus_write(2'd2, 16'h0040);
        tick();
        check("tx_irq idle", tx_irq, 1'b1);
        bus_write(2'd3, 16'h0041);
        tx_exp_q.push_back(8'h41);
        tick();
        check("tx_irq drops", tx_irq, 1'b0);
        bus_write(2'd3, 16'h0042);
        uart_tx_serve("tx2");
        ticks(2);
        check("tx_irq rises", tx_irq, 1'b1);
        ticks(20);
        check("no second load", ld_tx_req, 1'b0);
        check("tx queue empty", tx_exp_q.size(), 0);
        bus_write(2'd2, 16'h0000);

        // Receive with RIE.
        bus_write(2'd0, 16'h0040);
        uart_rx_send(8'h5A, "rx1");
        exp_q.push_back(16'h005A);
        bus_read(2'd0, d);
        check("RCSR done+rie", d, 16'h00C0);
        check("rx_irq set", rx_irq, 1'b1);
        read_rbuf("rx1");
        tick();
        bus_read(2'd0, d);
        check("RCSR done cleared", d, 16'h0040);
        tick();
        check("rx_irq cleared", rx_irq, 1'b0);
        bus_write(2'd0, 16'h0000);

        // Overrun: two bytes without an RBUF read.
        uart_rx_send(8'h31, "ovr1");
        uart_rx_send(8'h32, "ovr2");
        exp_q.push_back(16'hC032);
        bus_read(2'd0, d);
        check("ovr DONE", d, 16'h0080);
        read_rbuf("ovr");
        // Next byte after the read is clean again.
        uart_rx_send(8'h33, "rx3");
        exp_q.push_back(16'h0033);
        read_rbuf("rx3");

        // Enable set while flag already up: irq follows.
        uart_rx_send(8'h44, "rx4");
        bus_write(2'd0, 16'h0040);
        tick();
        check("late RIE irq", rx_irq, 1'b1);
        exp_q.push_back(16'h0044);
        read_rbuf("rx4");

        // Reset in the middle of a transmit request.
        bus_write(2'd3, 16'h0055);
        wait_tx_req(1'b1, ok);
        check("abort tx req up", ok, 1'b1);
        check("abort tx_data", tx_data, 8'h55);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        check("abort tx req 0", ld_tx_req, 1'b0);
        bus_read(2'd2, d);
        check("abort XCSR", d, 16'h0080);

        // Reset in the middle of a receive request.
        rx_data  = 8'h66;
        rx_empty = 1'b0;
        wait_rx_req(1'b1, ok);
        check("abort rx req up", ok, 1'b1);
        reset    = 1'b1;
        rx_empty = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        check("abort rx req 0", uld_rx_req, 1'b0);
        bus_read(2'd0, d);
        check("abort RCSR", d, 16'h0000);

        // Transfers after the aborts complete normally.
        bus_write(2'd3, 16'h00A5);
        tx_exp_q.push_back(8'hA5);
        uart_tx_serve("post tx");
        uart_rx_send(8'h77, "post rx");
        exp_q.push_back(16'h0077);
        read_rbuf("post rx");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
